mul_arbiter_ctrl: RTL and testbench

- Sequencer and arbiter for the shared 32x32 signed Booth-Wallace multiplier in the PE.
- Two requesters share the multiplier, e.g. integer pipe and vector/accumulate path.
- Grants requesters round-robin, registers operands into the multiplier, and waits a fixed multicycle-path latency.
- Applies sign correction for RV32M MUL/MULH/MULHSU/MULHU, then returns one 32-bit result over a valid/ready response channel.

---
 rtl/mul_arbiter_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_mul_arbiter_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter_ctrl.sv
// Round-robin sequencer for the shared 32x32 signed multiplier: two requesters, operand registers,
// fixed multicycle wait, RV32M sign correction, valid/ready response. Option: MUL_ZERO_SKIP_EN.
module mul_arbiter_ctrl #(
    parameter int MUL_LATENCY = 2,
    parameter int TAG_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [31:0]      mult_a,
    output logic [31:0]      mult_b,
    input  logic [63:0]      mult_p,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_data,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int              CNT_W    = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 1);

    // The multiplier is signed x signed; unsigned operands are fixed up on the high word only.
    function automatic logic [31:0] fix_product(
        input logic [1:0]  op,
        input logic [63:0] p,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] hi;
        logic [31:0] corr_a;
        logic [31:0] corr_b;
        hi     = p[63:32];
        corr_a = b[31] ? a : 32'd0;
        corr_b = a[31] ? b : 32'd0;
        case (op)
            2'b00:   fix_product = p[31:0];
            2'b01:   fix_product = hi;
            2'b10:   fix_product = hi + corr_a;
            2'b11:   fix_product = hi + corr_b + corr_a;
            default: fix_product = p[31:0];
        endcase
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             last_grant_r;
    logic [1:0]       op_r;
    logic [31:0]      mult_a_r;
    logic [31:0]      mult_b_r;
    logic             rsp_valid_r;
    logic             rsp_id_r;
    logic [TAG_W-1:0] rsp_tag_r;
    logic [31:0]      rsp_data_r;
    logic             busy_r;

    logic             grant0_s;
    logic             grant1_s;
    logic             accept_s;
    logic [31:0]      acc_a_s;
    logic [31:0]      acc_b_s;
    logic [1:0]       acc_op_s;
    logic [TAG_W-1:0] acc_tag_s;
    logic             zero_skip_s;

    // Round-robin grant, only offered while idle.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                if (last_grant_r) begin
                    grant0_s = 1'b1;
                end else begin
                    grant1_s = 1'b1;
                end
            end else if (req0_valid) begin
                grant0_s = 1'b1;
            end else if (req1_valid) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign accept_s   = grant0_s | grant1_s;

    assign acc_a_s   = grant1_s ? req1_a   : req0_a;
    assign acc_b_s   = grant1_s ? req1_b   : req0_b;
    assign acc_op_s  = grant1_s ? req1_op  : req0_op;
    assign acc_tag_s = grant1_s ? req1_tag : req0_tag;

`ifdef MUL_ZERO_SKIP_EN
    assign zero_skip_s = (acc_a_s == 32'd0) || (acc_b_s == 32'd0);
`else
    assign zero_skip_s = 1'b0;
`endif

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = zero_skip_s ? ST_DONE : ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == '0) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (rsp_valid_r && rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Operand, counter and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            last_grant_r <= 1'b1;
            op_r         <= 2'b00;
            mult_a_r     <= 32'd0;
            mult_b_r     <= 32'd0;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= 1'b0;
            rsp_tag_r    <= '0;
            rsp_data_r   <= 32'd0;
            busy_r       <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        last_grant_r <= grant1_s;
                        rsp_id_r     <= grant1_s;
                        rsp_tag_r    <= acc_tag_s;
                        op_r         <= acc_op_s;
                        mult_a_r     <= acc_a_s;
                        mult_b_r     <= acc_b_s;
                        cnt_r        <= CNT_LOAD;
                        if (zero_skip_s) begin
                            rsp_valid_r <= 1'b1;
                            rsp_data_r  <= 32'd0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt_r == '0) begin
                        rsp_valid_r <= 1'b1;
                        rsp_data_r  <= fix_product(op_r, mult_p, mult_a_r, mult_b_r);
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (rsp_valid_r && rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign mult_a    = mult_a_r;
    assign mult_b    = mult_b_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_tag   = rsp_tag_r;
    assign rsp_data  = rsp_data_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mul_arbiter_ctrl.sv
// Directed bench for mul_arbiter_ctrl with a behavioural signed multiplier; honours MUL_ZERO_SKIP_EN.
module tb_mul_arbiter_ctrl;

    localparam int LAT   = 2;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready;
    logic [1:0]       req0_op;
    logic [31:0]      req0_a, req0_b;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid, req1_ready;
    logic [1:0]       req1_op;
    logic [31:0]      req1_a, req1_b;
    logic [TAG_W-1:0] req1_tag;
    logic [31:0]      mult_a, mult_b;
    logic [63:0]      mult_p;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    logic [31:0]      rsp_data;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign mult_p = $signed({{32{mult_a[31]}}, mult_a}) * $signed({{32{mult_b[31]}}, mult_b});

    mul_arbiter_ctrl #(.MUL_LATENCY(LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_tag(rsp_tag), .rsp_data(rsp_data), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns just after the accepting posedge with valid dropped.
    task automatic issue(input logic id, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] tag);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_tag = tag;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_tag = tag;
        end
        #1;
        check(id ? "issue_ready1" : "issue_ready0", id ? req1_ready : req0_ready, 1'b1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // Waits for the response (bounded), checks it, optionally stalls, then handshakes once.
    task automatic wait_rsp(input int exp_lat, input logic exp_id, input logic [TAG_W-1:0] exp_tag,
                            input logic [31:0] exp_data, input int stall);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rsp_valid && k < 20);
        check("rsp_latency", k, exp_lat);
        check("rsp_id", rsp_id, exp_id);
        check("rsp_tag", rsp_tag, exp_tag);
        check("rsp_data", rsp_data, exp_data);
        check("busy_in_done", busy, 1'b1);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", rsp_valid, 1'b1);
            check("stall_data", rsp_data, exp_data);
            check("stall_ready0", req0_ready, 1'b0);
            check("stall_ready1", req1_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_hs_valid", rsp_valid, 1'b0);
        check("post_hs_busy", busy, 1'b0);
    endtask

    initial begin
        logic [TAG_W-1:0] tag0, tag1, old_tag;
        logic             g;
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_op = 2'b00; req0_a = 32'd0; req0_b = 32'd0; req0_tag = '0;
        req1_valid = 1'b0; req1_op = 2'b00; req1_a = 32'd0; req1_b = 32'd0; req1_tag = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_mult_a", mult_a, 32'd0);
        check("rst_mult_b", mult_b, 32'd0);
        check("rst_data", rsp_data, 32'd0);
        check("rst_tag", rsp_tag, 5'd0);
        check("rst_id", rsp_id, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Basic MUL and the high-word variants
        issue(1'b0, 2'b00, 32'd7, 32'hFFFF_FFFD, 5'd3);
        check("mult_a_loaded", mult_a, 32'd7);
        check("mult_b_loaded", mult_b, 32'hFFFF_FFFD);
        wait_rsp(LAT + 1, 1'b0, 5'd3, 32'hFFFF_FFEB, 0);
        issue(1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
        wait_rsp(LAT + 1, 1'b1, 5'd4, 32'hFFFF_FFFE, 0);
        issue(1'b0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
        wait_rsp(LAT + 1, 1'b0, 5'd5, 32'hFFFF_FFFF, 0);

        // Backpressure with requester 0 waiting behind
        issue(1'b1, 2'b00, 32'h0001_2345, 32'h0000_0100, 5'd7);
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'h8000_0000; req0_b = 32'h8000_0000; req0_tag = 5'd8;
        wait_rsp(LAT + 1, 1'b1, 5'd7, 32'h0123_4500, 5);
        #1;
        check("deferred_ready0", req0_ready, 1'b1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        wait_rsp(LAT + 1, 1'b0, 5'd8, 32'h4000_0000, 0);

        // Reset one cycle after accept
        issue(1'b0, 2'b00, 32'd5, 32'd6, 5'd9);
        @(negedge clk);
        check("busy_before_rst", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_valid", rsp_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_mult_a", mult_a, 32'd0);
        check("midrst_mult_b", mult_b, 32'd0);
        check("midrst_data", rsp_data, 32'd0);
        check("midrst_tag", rsp_tag, 5'd0);
        repeat (4) begin
            @(negedge clk);
            check("no_rsp_after_rst", rsp_valid, 1'b0);
        end

        // Both valid continuously: grants alternate starting at requester 0
        tag0 = 5'd10; tag1 = 5'd20;
        req0_op = 2'b00; req0_a = 32'd2; req0_b = 32'd3; req0_tag = tag0; req0_valid = 1'b1;
        req1_op = 2'b00; req1_a = 32'd4; req1_b = 32'd5; req1_tag = tag1; req1_valid = 1'b1;
        g = 1'b0;
        repeat (4) begin
            #1;
            check("arb_ready0", req0_ready, !g);
            check("arb_ready1", req1_ready, g);
            @(posedge clk);
            #1;
            if (g) begin
                old_tag = tag1; tag1 = tag1 + 5'd1; req1_tag = tag1;
            end else begin
                old_tag = tag0; tag0 = tag0 + 5'd1; req0_tag = tag0;
            end
            wait_rsp(LAT + 1, g, old_tag, g ? 32'd20 : 32'd6, 0);
            g = !g;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);

        // Zero operand: short path only when the option is built in
        issue(1'b0, 2'b00, 32'd0, 32'h0000_1234, 5'd1);
`ifdef MUL_ZERO_SKIP_EN
        wait_rsp(1, 1'b0, 5'd1, 32'd0, 0);
`else
        wait_rsp(LAT + 1, 1'b0, 5'd1, 32'd0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
